// File: rtl/melody_pkg.sv
// Shared constants, state encoding and helpers for the melody sequencer.
// Score entry layout is {tone[8:4], dur[3:0]}; a zero duration ends the song.
package melody_pkg;

    localparam int TONE_W  = 5;
    localparam int DUR_W   = 4;
    localparam int ENTRY_W = 9;

    localparam logic [TONE_W-1:0] TONE_REST = 5'd0;
    localparam logic [TONE_W-1:0] TONE_MAX  = 5'd21;
    localparam logic [DUR_W-1:0]  DUR_END   = 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP
    } state_t;

    // Codes outside 1..TONE_MAX are played as silence.
    function automatic logic is_audible(input logic [TONE_W-1:0] code);
        return (code != TONE_REST) && (code <= TONE_MAX);
    endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Bundle between control logic / score ROM / Beeper and the sequencer.
// slave: sequencer side (drives rom_addr, tone, tone_en, busy, done).
// master: environment side (drives start, stop, loop_en, rom_data).
interface melody_sequencer_if #(
    parameter int ADDR_W = 8
);
    import melody_pkg::*;

    logic                start;
    logic                stop;
    logic                loop_en;
    logic [ADDR_W-1:0]   rom_addr;
    logic [ENTRY_W-1:0]  rom_data;
    logic [TONE_W-1:0]   tone;
    logic                tone_en;
    logic                busy;
    logic                done;

    modport master (
        output start, stop, loop_en, rom_data,
        input  rom_addr, tone, tone_en, busy, done
    );

    modport slave (
        input  start, stop, loop_en, rom_data,
        output rom_addr, tone, tone_en, busy, done
    );

endinterface

// File: rtl/melody_sequencer_tick_prescaler.sv
// Divide-by-TICK_DIV strobe generator with synchronous clear and enable.
// Ports: clk_in, rst_in, clr (restart count), en (count), tick (1-cycle strobe).
module tick_prescaler #(
    parameter int TICK_DIV = 750000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Strobe on the last clock of each TICK_DIV period.
    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/melody_sequencer.sv
// Plays a score from an external synchronous ROM onto the Beeper tone inputs.
// Ports: clk_in, rst_in (sync, active-high), bus (start/stop/loop_en, ROM, tone out, busy/done).
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int TICK_DIV   = 750000,
    parameter int GAP_CYCLES = 120000,
    parameter int ADDR_W     = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    melody_sequencer_if.slave  bus
);

    if (TICK_DIV < 2 || GAP_CYCLES < 1 || CLK_HZ < TICK_DIV) begin : g_bad_params
        $error("melody_sequencer: illegal TICK_DIV/GAP_CYCLES/CLK_HZ");
    end

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t              state;
    logic [DUR_W-1:0]    cur_dur;
    logic [DUR_W-1:0]    tick_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [ADDR_W-1:0]   rom_addr;
    logic [TONE_W-1:0]   tone;
    logic                tone_en;
    logic                busy;
    logic                done;
    logic                tick;

    logic [TONE_W-1:0]   rd_tone;
    logic [DUR_W-1:0]    rd_dur;

    assign rd_tone = bus.rom_data[ENTRY_W-1:DUR_W];
    assign rd_dur  = bus.rom_data[DUR_W-1:0];

    // Prescaler restarts in LOAD so a note starts on a clean tick boundary.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (state == LOAD),
        .en     (state == PLAY),
        .tick   (tick)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            cur_dur  <= '0;
            tick_cnt <= '0;
            gap_cnt  <= '0;
            rom_addr <= '0;
            tone     <= TONE_REST;
            tone_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && bus.stop) begin
                // Abort: silence immediately, no done pulse.
                state    <= IDLE;
                rom_addr <= '0;
                tone     <= TONE_REST;
                tone_en  <= 1'b0;
                busy     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        tone_en <= 1'b0;
                        if (bus.start && !bus.stop) begin
                            rom_addr <= '0;
                            busy     <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        if (rd_dur == DUR_END) begin
                            rom_addr <= '0;
                            if (bus.loop_en) begin
                                state <= FETCH;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                tone  <= TONE_REST;
                                state <= IDLE;
                            end
                        end else begin
                            cur_dur  <= rd_dur;
                            tick_cnt <= '0;
                            state    <= PLAY;
                            if (is_audible(rd_tone)) begin
                                tone    <= rd_tone;
                                tone_en <= 1'b1;
                            end else begin
                                tone    <= TONE_REST;
                                tone_en <= 1'b0;
                            end
                        end
                    end
                    PLAY: begin
                        if (tick) begin
                            if (tick_cnt == cur_dur - DUR_W'(1)) begin
                                tone_en <= 1'b0;
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else begin
                                tick_cnt <= tick_cnt + DUR_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            state    <= FETCH;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr = rom_addr;
    assign bus.tone     = tone;
    assign bus.tone_en  = tone_en;
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule
